// File: rtl/btb_write_scheduler.sv
// Write-side scheduler for the banked BTB entry array: runs the invalidation
// sweep, then issues bank-conflict-free writes with an in-order overflow queue.
module btb_write_scheduler #(
    parameter int ENTRY_NUM   = 1024,
    parameter int BANK_NUM    = 2,
    parameter int REQ_NUM     = 2,
    parameter int WRITE_NUM   = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int DATA_BITS   = 48,
    parameter int INDEX_BITS  = $clog2(ENTRY_NUM)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [REQ_NUM-1:0]              reqValid,
    input  logic [REQ_NUM*INDEX_BITS-1:0]   reqIndex,
    input  logic [REQ_NUM*DATA_BITS-1:0]    reqData,
    output logic [WRITE_NUM-1:0]            wrEn,
    output logic [WRITE_NUM*INDEX_BITS-1:0] wrIndex,
    output logic [WRITE_NUM*DATA_BITS-1:0]  wrData,
    output logic                            initBusy,
    output logic [$clog2(QUEUE_DEPTH):0]    queueCount,
    output logic [7:0]                      dropCount
);

    localparam int PTR_BITS  = $clog2(QUEUE_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int BANK_BITS = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int PSEL_BITS = (WRITE_NUM > 1) ? $clog2(WRITE_NUM) : 1;
    localparam int PCNT_BITS = PSEL_BITS + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                                 state_q, state_d;
    logic [INDEX_BITS-1:0]                  sweep_q, sweep_d;
    logic [PTR_BITS-1:0]                    head_q, head_d;
    logic [CNT_BITS-1:0]                    count_q, count_d;
    logic [7:0]                             drop_q, drop_d;
    logic [QUEUE_DEPTH-1:0][INDEX_BITS-1:0] q_index_q, q_index_d;
    logic [QUEUE_DEPTH-1:0][DATA_BITS-1:0]  q_data_q, q_data_d;
    logic [WRITE_NUM-1:0]                   wr_en_q, wr_en_d;
    logic [WRITE_NUM-1:0][INDEX_BITS-1:0]   wr_index_q, wr_index_d;
    logic [WRITE_NUM-1:0][DATA_BITS-1:0]    wr_data_q, wr_data_d;
    logic                                   busy_q;

    logic [PCNT_BITS-1:0]  n_port_s;
    logic [CNT_BITS-1:0]   n_pop_s, n_push_s;
    logic [7:0]            n_drop_s;
    logic [PTR_BITS-1:0]   slot_s;
    logic [INDEX_BITS-1:0] idx_s;
    logic [DATA_BITS-1:0]  dat_s;
    logic [BANK_BITS-1:0]  bank_s;
    logic [BANK_NUM-1:0]   bank_busy_s;
    logic                  q_stop_s, l_stop_s, drained_s, room_s;
    logic                  lane_issue_s, lane_keep_s;

    // Next-state: sweep in INIT, greedy conflict-free pick plus enqueue in RUN.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        head_d       = head_q;
        count_d      = count_q;
        drop_d       = drop_q;
        q_index_d    = q_index_q;
        q_data_d     = q_data_q;
        wr_en_d      = '0;
        wr_index_d   = '0;
        wr_data_d    = '0;
        n_port_s     = '0;
        n_pop_s      = '0;
        n_push_s     = '0;
        n_drop_s     = 8'd0;
        slot_s       = '0;
        idx_s        = '0;
        dat_s        = '0;
        bank_s       = '0;
        bank_busy_s  = '0;
        q_stop_s     = 1'b0;
        l_stop_s     = 1'b0;
        drained_s    = 1'b0;
        room_s       = 1'b0;
        lane_issue_s = 1'b0;
        lane_keep_s  = 1'b0;

        if (flush) begin
            state_d = ST_INIT;
            sweep_d = '0;
            head_d  = '0;
            count_d = '0;
        end else if (state_q == ST_INIT) begin
            wr_en_d[0]    = 1'b1;
            wr_index_d[0] = sweep_q;
            sweep_d       = sweep_q + INDEX_BITS'(1);
            if (sweep_q == INDEX_BITS'(ENTRY_NUM - 1)) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_INIT;
            end
        end else begin
            // Queue drains strictly in order: first blocked entry ends the scan.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot_s = head_q + PTR_BITS'(i);
                idx_s  = q_index_q[slot_s];
                dat_s  = q_data_q[slot_s];
                bank_s = idx_s[BANK_BITS-1:0];
                if ((CNT_BITS'(i) < count_q) && !q_stop_s &&
                    (n_port_s < PCNT_BITS'(WRITE_NUM)) && !bank_busy_s[bank_s]) begin
                    wr_en_d[n_port_s[PSEL_BITS-1:0]]    = 1'b1;
                    wr_index_d[n_port_s[PSEL_BITS-1:0]] = idx_s;
                    wr_data_d[n_port_s[PSEL_BITS-1:0]]  = dat_s;
                    bank_busy_s[bank_s] = 1'b1;
                    n_port_s = n_port_s + PCNT_BITS'(1);
                    n_pop_s  = n_pop_s + CNT_BITS'(1);
                end else begin
                    q_stop_s = 1'b1;
                end
            end

            // New requests may bypass only once every queued entry has issued.
            drained_s = (n_pop_s == count_q);
            for (int l = 0; l < REQ_NUM; l++) begin
                idx_s  = reqIndex[l*INDEX_BITS +: INDEX_BITS];
                dat_s  = reqData[l*DATA_BITS +: DATA_BITS];
                bank_s = idx_s[BANK_BITS-1:0];
                lane_issue_s = reqValid[l] && !l_stop_s && drained_s &&
                               (n_port_s < PCNT_BITS'(WRITE_NUM)) && !bank_busy_s[bank_s];
                lane_keep_s  = reqValid[l] && !lane_issue_s;
                room_s       = ((count_q - n_pop_s + n_push_s) < CNT_BITS'(QUEUE_DEPTH));
                slot_s       = head_q + count_q[PTR_BITS-1:0] + n_push_s[PTR_BITS-1:0];
                if (lane_issue_s) begin
                    wr_en_d[n_port_s[PSEL_BITS-1:0]]    = 1'b1;
                    wr_index_d[n_port_s[PSEL_BITS-1:0]] = idx_s;
                    wr_data_d[n_port_s[PSEL_BITS-1:0]]  = dat_s;
                    bank_busy_s[bank_s] = 1'b1;
                    n_port_s = n_port_s + PCNT_BITS'(1);
                end else if (lane_keep_s && room_s) begin
                    q_index_d[slot_s] = idx_s;
                    q_data_d[slot_s]  = dat_s;
                    n_push_s = n_push_s + CNT_BITS'(1);
                end else begin
                    n_drop_s = n_drop_s + 8'(lane_keep_s);
                end
                l_stop_s = l_stop_s | lane_keep_s;
            end

            head_d  = head_q + n_pop_s[PTR_BITS-1:0];
            count_d = count_q - n_pop_s + n_push_s;
            if (n_drop_s > (8'd255 - drop_q)) begin
                drop_d = 8'd255;
            end else begin
                drop_d = drop_q + n_drop_s;
            end
        end
    end

    // State, queue and registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            head_q     <= '0;
            count_q    <= '0;
            drop_q     <= 8'd0;
            q_index_q  <= '0;
            q_data_q   <= '0;
            wr_en_q    <= '0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            head_q     <= head_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            q_index_q  <= q_index_d;
            q_data_q   <= q_data_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= (state_d == ST_INIT);
        end
    end

    assign wrEn       = wr_en_q;
    assign wrIndex    = wr_index_q;
    assign wrData     = wr_data_q;
    assign initBusy   = busy_q;
    assign queueCount = count_q;
    assign dropCount  = drop_q;

endmodule
